uplus_40g_tx_arbiter: RTL and testbench

UPLUS_40G_TX_ARBITER -- requirements
Module: uplus_40g_tx_arbiter

---
 rtl/uplus_40g_pkg.sv | 7 +
 rtl/uplus_rr_pick.sv | 25 ++
 rtl/uplus_40g_tx_arbiter.sv | 92 +++++++++
 tb/tb_uplus_40g_tx_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uplus_40g_pkg.sv
// uplus_40g_pkg: shared AXIS widths, jumbo beat limit and tx arbiter FSM encoding.
package uplus_40g_pkg;
    localparam int C_AXIS_DATA_W    = 256;
    localparam int C_AXIS_KEEP_W    = 32;
    localparam int C_MAX_BEATS_9600 = 300;
    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DRAIN} arb_state_t;
endpackage

// File: rtl/uplus_rr_pick.sv
// uplus_rr_pick: rotating-priority one-hot picker starting just after the last grant.
module uplus_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    int k;
    // walk lowest priority first so the highest-priority hit is written last
    always_comb begin
        grant = '0;
        idx   = '0;
        k     = 0;
        for (int i = N; i >= 1; i--) begin
            k = (int'(last) + i) % N;
            if (req[k]) begin
                grant = N'(1) << k;
                idx   = IW'(k);
            end
        end
    end
endmodule

// File: rtl/uplus_40g_tx_arbiter.sv
// uplus_40g_tx_arbiter: round-robin packet arbiter muxing AXIS sources onto the 40G MAC TX port,
// truncating over-length packets with tlast+tuser and draining their remainder.
module uplus_40g_tx_arbiter
    import uplus_40g_pkg::*;
#(
    parameter int P_NUM_SRC   = 4,
    parameter int P_MAX_BEATS = C_MAX_BEATS_9600
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_link_up,
    input  logic [P_NUM_SRC-1:0]               s_axis_tvalid,
    output logic [P_NUM_SRC-1:0]               s_axis_tready,
    input  logic [P_NUM_SRC-1:0]               s_axis_tlast,
    input  logic [P_NUM_SRC-1:0]               s_axis_tuser,
    input  logic [C_AXIS_DATA_W*P_NUM_SRC-1:0] s_axis_tdata,
    input  logic [C_AXIS_KEEP_W*P_NUM_SRC-1:0] s_axis_tkeep,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic                               m_axis_tuser,
    output logic [C_AXIS_DATA_W-1:0]           m_axis_tdata,
    output logic [C_AXIS_KEEP_W-1:0]           m_axis_tkeep,
    output logic [P_NUM_SRC-1:0]               o_grant,
    output logic [15:0]                        o_trunc_cnt
);
    localparam int IW = (P_NUM_SRC > 1) ? $clog2(P_NUM_SRC) : 1;
    localparam logic [8:0] LAST_BEAT = 9'(P_MAX_BEATS - 1);

    arb_state_t state, state_nxt;
    logic [IW-1:0] gidx, last_grant, pick_idx;
    logic [P_NUM_SRC-1:0] pick;
    logic [8:0] beat_cnt;
    logic src_valid, src_last, accept, trunc_beat, drain_done;

    uplus_rr_pick #(.N(P_NUM_SRC), .IW(IW)) u_pick (
        .req  (s_axis_tvalid),
        .last (last_grant),
        .grant(pick),
        .idx  (pick_idx)
    );

    assign src_valid  = s_axis_tvalid[gidx];
    assign src_last   = s_axis_tlast[gidx];
    assign trunc_beat = (state == ST_XFER) && (beat_cnt == LAST_BEAT) && !src_last;
    assign accept     = m_axis_tvalid && m_axis_tready;
    assign drain_done = (state == ST_DRAIN) && src_valid && src_last;

    always_comb begin
        m_axis_tvalid = (state == ST_XFER) && src_valid;
        m_axis_tlast  = src_last | trunc_beat;
        m_axis_tuser  = s_axis_tuser[gidx] | trunc_beat;
        m_axis_tdata  = s_axis_tdata[gidx*C_AXIS_DATA_W +: C_AXIS_DATA_W];
        m_axis_tkeep  = s_axis_tkeep[gidx*C_AXIS_KEEP_W +: C_AXIS_KEEP_W];
        s_axis_tready = (state == ST_XFER)  ? (o_grant & {P_NUM_SRC{m_axis_tready}}) :
                        (state == ST_DRAIN) ? o_grant : '0;
        state_nxt     = state;
        case (state)
            ST_IDLE:  state_nxt = (i_link_up && |s_axis_tvalid) ? ST_XFER : ST_IDLE;
            ST_XFER:  state_nxt = !accept ? ST_XFER : src_last ? ST_IDLE :
                                  trunc_beat ? ST_DRAIN : ST_XFER;
            ST_DRAIN: state_nxt = drain_done ? ST_IDLE : ST_DRAIN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            o_grant     <= '0;
            gidx        <= '0;
            last_grant  <= IW'(P_NUM_SRC - 1);
            beat_cnt    <= '0;
            o_trunc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_XFER) begin
                o_grant  <= pick;
                gidx     <= pick_idx;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 9'd1;
            end
            if (accept && trunc_beat && o_trunc_cnt != 16'hFFFF)
                o_trunc_cnt <= o_trunc_cnt + 16'd1;
            if (state != ST_IDLE && state_nxt == ST_IDLE) begin
                o_grant    <= '0;
                last_grant <= gidx;
            end
        end
    end
endmodule

// File: tb/tb_uplus_40g_tx_arbiter.sv
// tb_uplus_40g_tx_arbiter: directed scenarios for the 40G TX arbiter with packet-generating sources.
module tb_uplus_40g_tx_arbiter;
    localparam int NS = 4;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_link_up = 1'b0;
    logic [NS-1:0]   s_axis_tvalid = '0, s_axis_tready, s_axis_tlast = '0, s_axis_tuser = '0;
    logic [256*NS-1:0] s_axis_tdata = '0;
    logic [32*NS-1:0]  s_axis_tkeep = '0;
    logic            m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast, m_axis_tuser;
    logic [255:0]    m_axis_tdata;
    logic [31:0]     m_axis_tkeep;
    logic [NS-1:0]   o_grant;
    logic [15:0]     o_trunc_cnt;

    int n_checks = 0, n_pass = 0;
    int len[NS], pos[NS], pk[NS];
    logic [NS-1:0] acc;
    logic [31:0] log_data[$], log_keep[$];
    logic log_last[$], log_user[$];

    uplus_40g_tx_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_link_up(i_link_up),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .o_grant(o_grant), .o_trunc_cnt(o_trunc_cnt)
    );

    always #5 i_clk = ~i_clk;

    // source model: data word carries {source, beat index}; last beat keeps 8 bytes
    task automatic drive();
        for (int n = 0; n < NS; n++) begin
            s_axis_tvalid[n] = pk[n] > 0;
            s_axis_tlast[n]  = pos[n] == len[n] - 1;
            s_axis_tdata[n*256 +: 256] = 256'({8'(n), 16'(pos[n])});
            s_axis_tkeep[n*32 +: 32]   = (pos[n] == len[n] - 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        end
    endtask

    task automatic advance();
        drive();
        #1;
        acc = s_axis_tvalid & s_axis_tready;
        n_checks++;
        if ($countones(s_axis_tready) > 1) $display("FAIL tready_onehot: got %b required at most one bit", s_axis_tready);
        else n_pass++;
        if (m_axis_tvalid && m_axis_tready) begin
            log_data.push_back(m_axis_tdata[31:0]);
            log_keep.push_back(m_axis_tkeep);
            log_last.push_back(m_axis_tlast);
            log_user.push_back(m_axis_tuser);
        end
        @(posedge i_clk);
        for (int n = 0; n < NS; n++)
            if (acc[n]) begin
                if (pos[n] == len[n] - 1) begin pos[n] = 0; pk[n]--; end
                else pos[n]++;
            end
        @(negedge i_clk);
        drive();
        #1;
    endtask

    task automatic clear_log();
        log_data.delete(); log_keep.delete(); log_last.delete(); log_user.delete();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        advance(); advance();
        i_rst = 1'b0;
        n_checks += 4;
        if (o_grant !== 4'b0) $display("FAIL reset_grant: got %b required 0000", o_grant); else n_pass++;
        if (s_axis_tready !== 4'b0) $display("FAIL reset_tready: got %b required 0000", s_axis_tready); else n_pass++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL reset_mvalid: got %b required 0", m_axis_tvalid); else n_pass++;
        if (o_trunc_cnt !== 16'd0) $display("FAIL reset_trunc: got %0d required 0", o_trunc_cnt); else n_pass++;
    endtask

    task automatic test_two_sources();
        logic [3:0] exp_g[10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                   4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        clear_log();
        i_link_up = 1'b1; m_axis_tready = 1'b1;
        len[0] = 4; pk[0] = 1; len[2] = 4; pk[2] = 1;
        for (int k = 0; k < 10; k++) begin
            advance();
            n_checks++;
            if (o_grant !== exp_g[k]) $display("FAIL two_src_grant[%0d]: got %b required %b", k, o_grant, exp_g[k]);
            else n_pass++;
        end
        n_checks++;
        if (log_data.size() != 8) $display("FAIL two_src_count: got %0d required 8", log_data.size());
        else begin
            n_pass++;
            for (int b = 0; b < 8; b++) begin
                n_checks++;
                if (log_data[b] !== {8'd0, (b < 4) ? 8'd0 : 8'd2, 16'(b % 4)} || log_last[b] !== (b % 4 == 3))
                    $display("FAIL two_src_beat[%0d]: got %h last %b", b, log_data[b], log_last[b]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        test_reset();
        clear_log();
        for (int n = 0; n < NS; n++) begin len[n] = 1; pk[n] = 1; end
        pk[0] = 2;
        for (int k = 1; k <= 10; k++) begin
            advance();
            exp_g = (k % 2 == 1) ? 4'(1 << (((k - 1) / 2) % 4)) : 4'b0;
            n_checks++;
            if (o_grant !== exp_g) $display("FAIL rr_grant[%0d]: got %b required %b", k, o_grant, exp_g);
            else n_pass++;
        end
        n_checks++;
        if (log_data.size() != 5 || log_data[4][23:16] !== 8'd0 || log_data[3][23:16] !== 8'd3)
            $display("FAIL rr_order: got %0d beats, 4th src %0d, 5th src %0d required 5/3/0",
                     log_data.size(), log_data[3][23:16], log_data[4][23:16]);
        else n_pass++;
    endtask

    task automatic test_truncate();
        int users;
        clear_log();
        len[1] = 310; pk[1] = 1;
        for (int k = 0; k < 400 && pk[1] != 0; k++) advance();
        users = 0;
        foreach (log_user[i]) users += int'(log_user[i]);
        n_checks += 6;
        if (pk[1] != 0) $display("FAIL trunc_drain: source 1 still holds %0d packets, required 0", pk[1]); else n_pass++;
        if (log_data.size() != 300) $display("FAIL trunc_count: got %0d beats required 300", log_data.size()); else n_pass++;
        if (log_data.size() == 300 && (log_last[299] !== 1'b1 || log_user[299] !== 1'b1 || log_data[299] !== 32'h0001_012B))
            $display("FAIL trunc_last_beat: got data %h last %b user %b required 0001012b/1/1",
                     log_data[299], log_last[299], log_user[299]);
        else n_pass++;
        if (users != 1) $display("FAIL trunc_user_count: got %0d required 1", users); else n_pass++;
        if (o_trunc_cnt !== 16'd1) $display("FAIL trunc_cnt: got %0d required 1", o_trunc_cnt); else n_pass++;
        if (o_grant !== 4'b0) $display("FAIL trunc_idle: got %b required 0000", o_grant); else n_pass++;
        clear_log();
        len[1] = 300; pk[1] = 1;
        for (int k = 0; k < 400 && pk[1] != 0; k++) advance();
        n_checks += 2;
        if (log_data.size() != 300 || log_last[299] !== 1'b1 || log_user[299] !== 1'b0)
            $display("FAIL exact300: got %0d beats required 300 with last=1 user=0", log_data.size());
        else n_pass++;
        if (o_trunc_cnt !== 16'd1) $display("FAIL exact300_cnt: got %0d required 1", o_trunc_cnt); else n_pass++;
    endtask

    task automatic test_link();
        clear_log();
        i_link_up = 1'b0;
        len[3] = 2; pk[3] = 1;
        for (int k = 0; k < 3; k++) begin
            advance();
            n_checks++;
            if (o_grant !== 4'b0 || s_axis_tready !== 4'b0)
                $display("FAIL link_down_hold[%0d]: got grant %b tready %b required 0000/0000", k, o_grant, s_axis_tready);
            else n_pass++;
        end
        i_link_up = 1'b1;
        advance();
        n_checks++;
        if (o_grant !== 4'b1000) $display("FAIL link_up_grant: got %b required 1000", o_grant); else n_pass++;
        i_link_up = 1'b0;
        advance(); advance();
        n_checks++;
        if (log_data.size() != 2 || log_last[1] !== 1'b1 || log_data[1] !== 32'h0003_0001)
            $display("FAIL link_drop_complete: got %0d beats required 2 ending 00030001", log_data.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_log();
        i_link_up = 1'b1;
        len[0] = 8; pk[0] = 1;
        for (int k = 0; k < 40 && pk[0] != 0; k++) begin
            m_axis_tready = k[0];
            advance();
        end
        m_axis_tready = 1'b1;
        n_checks++;
        if (log_data.size() != 8) $display("FAIL bp_count: got %0d required 8", log_data.size());
        else begin
            n_pass++;
            for (int b = 0; b < 8; b++) begin
                n_checks++;
                if (log_data[b] !== 32'(b) || log_keep[b] !== ((b == 7) ? 32'h0000_00FF : 32'hFFFF_FFFF)
                    || log_last[b] !== (b == 7))
                    $display("FAIL bp_beat[%0d]: got data %h keep %h last %b", b, log_data[b], log_keep[b], log_last[b]);
                else n_pass++;
            end
        end
        clear_log();
        pk[0] = 1;
        for (int k = 0; k < 20 && log_data.size() < 5; k++) advance();
        i_rst = 1'b1;
        advance();
        n_checks += 4;
        if (o_grant !== 4'b0) $display("FAIL midrst_grant: got %b required 0000", o_grant); else n_pass++;
        if (s_axis_tready !== 4'b0) $display("FAIL midrst_tready: got %b required 0000", s_axis_tready); else n_pass++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL midrst_mvalid: got %b required 0", m_axis_tvalid); else n_pass++;
        if (o_trunc_cnt !== 16'd0) $display("FAIL midrst_trunc: got %0d required 0", o_trunc_cnt); else n_pass++;
        i_rst = 1'b0;
        for (int n = 0; n < NS; n++) begin pk[n] = 0; pos[n] = 0; end
    endtask

    initial begin
        for (int n = 0; n < NS; n++) begin len[n] = 1; pos[n] = 0; pk[n] = 0; end
        @(negedge i_clk);
        test_reset();
        test_two_sources();
        test_round_robin();
        test_truncate();
        test_link();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
